// File: rtl/cnt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_arbiter_pkg
// Purpose  : Shared types and default sizing for the cnt_arbiter block.
//            Holds the scheduler state enum and the default requester count
//            and counter width.
// Revision : 1.0 - initial release
// ============================================================================
package cnt_arbiter_pkg;

    // Default number of requesters and counter / interval width
    localparam int c_DEF_NREQ = 4;
    localparam int c_DEF_W    = 8;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : cnt_arbiter_pkg
`default_nettype wire

// File: rtl/cnt_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : Combinational round-robin pick. Searches req_i starting at index
//            ptr_i, then ptr_i+1, ... wrapping modulo NREQ, and reports the
//            first requester found.
// Ports    : req_i    [NREQ-1:0]  request levels
//            ptr_i    [PW-1:0]    highest-priority index for this search
//            valid_o              at least one request present
//            winner_o [PW-1:0]    index of the selected requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [PW-1:0]   winner_o
);

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        // First hit in rotated order wins; later hits are masked by valid_o.
        for (int k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[PW'((int'(ptr_i) + k) % NREQ)]) begin
                valid_o  = 1'b1;
                winner_o = PW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule : rr_arb
`default_nettype wire

// File: rtl/cnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnt_arbiter
// Purpose  : Shared interval-counter scheduler. Arbitrates NREQ requesters
//            round-robin for one W-bit down-counter, loads the winner's
//            interval length, counts it down (pausable with hold) and returns
//            a one-cycle done pulse to the winner.
// Ports    : clk               clock, all state on rising edge
//            rst               asynchronous active-high reset
//            req  [NREQ-1:0]   per-requester request level
//            len  [NREQ*W-1:0] per-requester interval length, slice i*W +: W
//            hold              pauses the count while high
//            gnt  [NREQ-1:0]   registered one-hot grant
//            done [NREQ-1:0]   registered one-cycle completion pulse
//            busy              high whenever the scheduler is not idle
//            cnt  [W-1:0]      current counter value
// Revision : 1.0 - initial release
// ============================================================================
module cnt_arbiter
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int W    = c_DEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      cnt
);

    localparam int c_PW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [W-1:0]      cnt_q,   cnt_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic [c_PW-1:0]   ptr_q,   ptr_d;
    logic [c_PW-1:0]   idx_q,   idx_d;

    logic              w_valid;
    logic [c_PW-1:0]   w_winner;
    logic [W-1:0]      w_len_win;

    rr_arb #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_rr_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (w_valid),
        .winner_o (w_winner)
    );

    assign w_len_win = len[int'(w_winner)*W +: W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (w_valid) begin
                    state_d = ST_COUNT;
                    cnt_d   = w_len_win;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                    idx_d   = w_winner;
                    ptr_d   = (w_winner == c_PW'(NREQ-1)) ? '0 : w_winner + 1'b1;
                end
            end

            ST_COUNT: begin
                // Abort takes precedence over hold: a dropped request ends
                // the interval even while the count is paused.
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (!hold) begin
                    // len=0 loads 0 and is finished like len=1, so no wrap.
                    if (cnt_q <= W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = gnt_q;
                    end else begin
                        cnt_d = cnt_q - W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);
    assign cnt  = cnt_q;

endmodule : cnt_arbiter
`default_nettype wire

// File: tb/tb_cnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_arbiter
// Purpose  : Self-checking bench for cnt_arbiter: directed scenarios followed
//            by randomized traffic, compared every cycle against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic              hold;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: who owns the counter, whether the owner's interval
    // has finished (done cycle), remaining value, next priority index.
    int              m_owner;
    bit              m_fin;
    int              m_ptr;
    logic [W-1:0]    m_cnt;
    logic [NREQ-1:0] m_gnt;
    logic [NREQ-1:0] m_done;
    logic [NREQ-1:0] prev_done;

    cnt_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
        .hold (hold),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_fin     = 1'b0;
        m_ptr     = 0;
        m_cnt     = '0;
        m_gnt     = '0;
        m_done    = '0;
        prev_done = '0;
    endtask

    // One clock of the scheduler rules, using the inputs present at the edge.
    task automatic model_edge();
        m_done = '0;
        if (rst) begin
            model_reset();
        end else if (m_fin) begin
            m_fin   = 1'b0;
            m_owner = -1;
            m_gnt   = '0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (m_owner < 0 && req[i]) begin
                    m_owner = i;
                    m_cnt   = len[i*W +: W];
                    m_ptr   = (i + 1) % NREQ;
                    m_gnt   = NREQ'(1) << i;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            m_gnt   = '0;
        end else if (!hold) begin
            if (m_cnt == 0 || m_cnt == 1) begin
                m_fin  = 1'b1;
                m_done = NREQ'(1) << m_owner;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    // Advance one clock, then compare every output with the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt",  32'(gnt),  32'(m_gnt));
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("cnt",  32'(cnt),  32'(m_cnt));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("done_consec", 32'(prev_done & done), 32'd0);
        prev_done = done;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*W +: W] = W'(v);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        len  = '0;
        hold = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt",  32'(cnt),  32'd0);

        // Single request, len 3
        req = 4'b0001;
        set_len(0, 3);
        step();
        chk("single_gnt_c1", 32'(gnt), 32'h1);
        chk("single_cnt_c1", 32'(cnt), 32'd3);
        step();
        chk("single_cnt_c2", 32'(cnt), 32'd2);
        step();
        chk("single_cnt_c3", 32'(cnt), 32'd1);
        chk("single_nodone_c3", 32'(done), 32'd0);
        step();
        chk("single_done_c4", 32'(done), 32'h1);
        chk("single_gnt_c4", 32'(gnt), 32'h1);
        req = '0;
        step();
        chk("single_busy_c5", 32'(busy), 32'd0);
        step();

        // Round-robin with pointer back at 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % NREQ)));
            step();
            chk("rr_done", 32'(done), 32'(1 << (k % NREQ)));
            step();
            chk("rr_idle", 32'(busy), 32'd0);
        end
        req = '0;
        step();

        // Hold stretches a len=2 interval by two cycles
        req = 4'b0010;
        set_len(1, 2);
        step();
        chk("hold_cnt_c1", 32'(cnt), 32'd2);
        step();
        chk("hold_cnt_c2", 32'(cnt), 32'd1);
        hold = 1'b1;
        step();
        chk("hold_cnt_c3", 32'(cnt), 32'd1);
        chk("hold_nodone_c3", 32'(done), 32'd0);
        step();
        chk("hold_cnt_c4", 32'(cnt), 32'd1);
        hold = 1'b0;
        step();
        chk("hold_done_c5", 32'(done), 32'h2);
        req = '0;
        step();
        step();

        // len=0 gives a single count cycle with no underflow
        req = 4'b1000;
        set_len(3, 0);
        step();
        chk("len0_cnt_c1", 32'(cnt), 32'd0);
        chk("len0_gnt_c1", 32'(gnt), 32'h8);
        step();
        chk("len0_done_c2", 32'(done), 32'h8);
        chk("len0_cnt_c2", 32'(cnt), 32'd0);
        req = '0;
        step();
        step();

        // Abort of requester 0, requester 1 pending
        req = 4'b0011;
        set_len(0, 5);
        set_len(1, 2);
        step();
        chk("abort_gnt_c1", 32'(gnt), 32'h1);
        step();
        req[0] = 1'b0;
        step();
        chk("abort_gnt_c3", 32'(gnt), 32'd0);
        chk("abort_busy_c3", 32'(busy), 32'd0);
        chk("abort_done_c3", 32'(done), 32'd0);
        step();
        chk("abort_gnt_c4", 32'(gnt), 32'h2);
        repeat (4) step();
        req = '0;
        step();
        step();

        // Asynchronous reset in the middle of an interval
        req = 4'b1100;
        set_len(2, 6);
        set_len(3, 6);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_gnt",  32'(gnt),  32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cnt",  32'(cnt),  32'd0);
        step();
        rst = 1'b0;
        step();
        chk("arst_first_gnt", 32'(gnt), 32'h4);
        req = '0;
        repeat (8) step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                set_len(i, int'($urandom_range(0, 6)));
            end
            hold = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_cnt_arbiter
`default_nettype wire

// File: doc/cnt_arbiter.md
# cnt_arbiter

Shared interval-counter scheduler: arbitrates up to NREQ requesters for a single W-bit down-counter resource, loads the winner's requested interval length, counts it down, and returns a one-cycle done pulse to that requester. It sits in front of the counter datapath so several clients can time intervals on one counter without contention.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, counter / interval length width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level; held until done or abort
- len  in  NREQ*W  per-requester interval length, slice i = len[i*W +: W]
- hold  in  1  freezes the count (pause) while high
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-cycle completion pulse to granted requester, registered
- busy  out  1  high whenever state != IDLE
- cnt  out  W  current counter value

## Operation
- States: IDLE, COUNT, DONE.
- IDLE: if any req, pick winner by round-robin, load cnt <= len[winner], gnt <= onehot(winner), go COUNT. No req: stay, gnt=0.
- Round-robin: pointer ptr (index, reset 0) = highest-priority index; search ptr, ptr+1, ... wrapping mod NREQ. On grant, ptr <= winner+1 (wraps NREQ-1 -> 0).
- COUNT, hold=1: cnt and state frozen.
- COUNT, hold=0: if cnt <= 1, go DONE; else cnt <= cnt-1.
- len=0 treated as len=1 (one COUNT cycle); never underflows.
- Abort: in COUNT, if req[granted] == 0 (checked before hold), go IDLE next cycle, gnt cleared, no done; ptr already advanced, so the requester counts as served.
- DONE: done[granted]=1 for exactly one cycle, gnt still asserted, cnt holds value; next state IDLE, gnt cleared. hold ignored in DONE.
- len sampled only at grant; changes during COUNT ignored.
- req from non-granted requesters ignored until IDLE.

## Timing
- Reset values: state IDLE, gnt=0, done=0, busy=0, cnt=0, ptr=0.
- Reset mid-operation: immediate return to reset values, no done pulse.
- req sampled in IDLE at cycle t -> gnt/busy high at t+1.
- Interval L>=1, no hold: COUNT lasts L cycles, DONE on cycle t+1+L, IDLE on t+2+L.
- Each hold-high COUNT cycle extends the interval by one cycle.
- Back-to-back: DONE -> IDLE -> next gnt; minimum two-cycle gap between consecutive grants' DONE and next COUNT (one IDLE cycle).
- done never asserted for two consecutive cycles; at most one gnt bit set.

## Structure
- Shared package: state enum (IDLE, COUNT, DONE), default NREQ/W constants.
- One sub-module: rr_arb (combinational round-robin pick from req and ptr, outputs valid + winner index); ptr register kept in cnt_arbiter.
- Remaining logic (FSM, counter, output regs) inline in cnt_arbiter.

## Test plan
- Reset: assert rst mid-run -> gnt=0, done=0, busy=0, cnt=0 same cycle; after release, req[2]=1 wins first grant only as ptr=0 search reaches it.
- Single request: req[0]=1, len[0]=3 at cycle 0 -> gnt=0001 cycles 1-4, cnt 3,2,1 cycles 1-3, done[0]=1 only cycle 4, busy low cycle 5.
- Round-robin: req=1111, all len=1, held -> grant order 0,1,2,3,0; each done spaced 3 cycles apart.
- Hold: req[1]=1, len=2, hold high cycles 2-3 -> done[1] at cycle 5 instead of 3, cnt frozen at 1 during hold.
- len=0: req[3]=1, len=0 -> one COUNT cycle with cnt=0, done[3] at cycle 2, no underflow.
- Abort: req[0] drops at cycle 2 of len=5 interval -> IDLE cycle 3, gnt=0, no done; pending req[1] granted cycle 4.
